// File: rtl/shift_pipe_pkg.sv
// Shared types and elaboration helpers for the radix-3 pipelined shifter.
// Holds the opcode encoding, the stage-count function and the shift-amount digit decoder.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  localparam int MAX_STAGE = 16;
  localparam int DIG_W     = 2 * MAX_STAGE;

  // Smallest r with 3**r >= n.
  function automatic int clog3(input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < MAX_STAGE; i++) begin
      if (p < n) begin
        p = p * 3;
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Base-3 digits of shamt, two bits per digit, least significant digit in [1:0].
  function automatic logic [DIG_W-1:0] to_base3(input logic [31:0] shamt, input int nstage);
    logic [31:0]      v;
    logic [DIG_W-1:0] d;
    v = shamt;
    d = '0;
    for (int k = 0; k < MAX_STAGE; k++) begin
      if (k < nstage) begin
        d[2*k +: 2] = 2'(v % 32'd3);
        v = v / 32'd3;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Operand/result channel of shift_pipe.
// Handshake: a beat transfers on a rising edge where valid and ready are both high; once
// valid is raised the sender holds valid and its payload steady until that transfer happens.
interface shift_pipe_if
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  op_e              in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

endinterface

// File: rtl/shift_stage_3_1.sv
// One radix-3 shifter stage: picks a shift of 0, 3**K or 2*3**K in the requested mode.
// Purely combinational; the stage register lives in the top level.
module shift_stage_3_1
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_digit,
  input  op_e              i_op,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  localparam int STEP = 3 ** K;

  // amt is an elaboration constant; amounts >= WIDTH are unreachable but must still build.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input op_e op,
                                                input logic sign, input int amt);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;
    int               a;
    ones = '1;
    fill = {WIDTH{sign}};
    a    = amt % WIDTH;
    case (op)
      OP_SLL:  res = (amt >= WIDTH) ? '0 : (d << amt);
      OP_SRL:  res = (amt >= WIDTH) ? '0 : (d >> amt);
      OP_SRA:  res = (amt >= WIDTH) ? fill : ((d >> amt) | (fill & ~(ones >> amt)));
      default: res = (a == 0) ? d : ((d >> a) | (d << (WIDTH - a)));
    endcase
    return res;
  endfunction

  always_comb begin
    o_data = i_data;
    case (i_digit)
      2'd1:    o_data = shift_by(i_data, i_op, i_sign, STEP);
      2'd2:    o_data = shift_by(i_data, i_op, i_sign, 2 * STEP);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) built from NSTAGE registered radix-3 stages.
// Each stage stalls only when its successor is full and not draining; flush empties all stages.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  shift_pipe_if.slave bus
);

  localparam int NSTAGE = clog3(WIDTH);
  localparam int DW     = 2 * NSTAGE;

  logic [NSTAGE-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [NSTAGE];
  op_e               r_op   [NSTAGE];
  logic              r_sign [NSTAGE];
  logic [DW-1:0]     r_dig  [NSTAGE];

  logic [NSTAGE:0]   w_ok;
  logic [NSTAGE-1:0] w_adv;
  logic              w_load [NSTAGE];
  logic [WIDTH-1:0]  w_src  [NSTAGE];
  logic [WIDTH-1:0]  w_res  [NSTAGE];
  logic [DW-1:0]     w_dsrc [NSTAGE];
  op_e               w_osrc [NSTAGE];
  logic              w_ssrc [NSTAGE];
  logic [DW-1:0]     w_dig0;
  logic              w_accept;

  assign w_dig0 = DW'(to_base3(32'(bus.in_shamt), NSTAGE));

  // w_ok[k]: stage k can take new data this edge. Walks back from out_ready so a drain
  // at the output frees every stage behind it in the same cycle.
  always_comb begin
    w_ok  = '0;
    w_adv = '0;
    w_ok[NSTAGE] = bus.out_ready;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      w_adv[k] = r_valid[k] && w_ok[k+1];
      w_ok[k]  = !r_valid[k] || w_ok[k+1];
    end
  end

  assign bus.in_ready = !i_flush && w_ok[0];
  assign w_accept     = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_src[k]  = bus.in_data;
      assign w_dsrc[k] = w_dig0;
      assign w_osrc[k] = bus.in_op;
      assign w_ssrc[k] = bus.in_data[WIDTH-1];
      assign w_load[k] = w_accept;
    end else begin : g_next
      assign w_src[k]  = r_data[k-1];
      assign w_dsrc[k] = r_dig[k-1];
      assign w_osrc[k] = r_op[k-1];
      assign w_ssrc[k] = r_sign[k-1];
      assign w_load[k] = !i_flush && w_adv[k-1];
    end

    shift_stage_3_1 #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .i_data  (w_src[k]),
      .i_digit (w_dsrc[k][1:0]),
      .i_op    (w_osrc[k]),
      .i_sign  (w_ssrc[k]),
      .o_data  (w_res[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        r_data[k] <= '0;
        r_op[k]   <= OP_SLL;
        r_sign[k] <= 1'b0;
        r_dig[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (i_flush)        r_valid[k] <= 1'b0;
        else if (w_load[k]) r_valid[k] <= 1'b1;
        else if (w_adv[k])  r_valid[k] <= 1'b0;
        // Payload only moves on a real load, so flushed stages keep their old data.
        if (w_load[k]) begin
          r_data[k] <= w_res[k];
          r_op[k]   <= w_osrc[k];
          r_sign[k] <= w_ssrc[k];
          r_dig[k]  <= w_dsrc[k] >> 2;
        end
      end
    end
  end

  assign bus.out_valid = r_valid[NSTAGE-1];
  assign bus.out_data  = r_data[NSTAGE-1];
  assign bus.out_zero  = (r_data[NSTAGE-1] == '0);

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe at WIDTH=16 and WIDTH=32 against an arithmetic shift model.
module tb_shift_pipe;
  import shift_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush16;
  logic        flush32;
  int          n_checks;
  int          n_fail;
  int          n_xfer;
  logic [15:0] exp_q[$];
  logic        prev_stall;
  logic [15:0] prev_data;

  shift_pipe_if #(.WIDTH(16)) b16 ();
  shift_pipe_if #(.WIDTH(32)) b32 ();

  shift_pipe #(.WIDTH(16)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush16), .bus(b16));
  shift_pipe #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush32), .bus(b32));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input int w, input logic [1:0] op,
                                            input logic [31:0] d, input int s);
    logic [63:0] x;
    logic [63:0] mask;
    logic [63:0] dd;
    mask = (64'd1 << w) - 64'd1;
    dd   = {32'd0, d} & mask;
    case (op)
      2'd0: x = (dd << s) & mask;
      2'd1: x = dd >> s;
      2'd2: begin
        x = dd >> s;
        if (dd[w-1]) x = x | (mask & ~(mask >> s));
      end
      default: x = ((dd >> s) | (dd << (w - s))) & mask;
    endcase
    return x[31:0];
  endfunction

  // ---------------- scoreboard / monitor (16-bit instance) ----------------
  always @(negedge clk) begin : mon16
    logic [31:0] e32;
    logic [15:0] e16;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (b16.out_valid !== 1'b1 || b16.out_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h",
                   b16.out_valid, b16.out_data, prev_data);
        end
      end
      if (b16.out_valid && b16.out_ready) begin
        n_xfer++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: data=%h required no output", b16.out_data);
        end else begin
          e16 = exp_q.pop_front();
          if (b16.out_data !== e16 || b16.out_zero !== (e16 == 16'd0)) begin
            n_fail++;
            $display("FAIL result: data=%h zero=%b required data=%h zero=%b",
                     b16.out_data, b16.out_zero, e16, (e16 == 16'd0));
          end
        end
      end
      if (flush16) begin
        exp_q.delete();
      end else if (b16.in_valid && b16.in_ready) begin
        e32 = ref_shift(16, b16.in_op, {16'd0, b16.in_data}, int'(b16.in_shamt));
        exp_q.push_back(e32[15:0]);
      end
      prev_stall = b16.out_valid && !b16.out_ready && !flush16;
      prev_data  = b16.out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [1:0] op, input logic [15:0] d, input logic [3:0] s);
    int n;
    b16.in_valid = 1'b1;
    b16.in_op    = op_e'(op);
    b16.in_data  = d;
    b16.in_shamt = s;
    n = 0;
    @(negedge clk);
    while (!b16.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout: in_ready=%b required 1 within 20 cycles", b16.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single16(input string name, input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] s, input logic [15:0] expv);
    int lat;
    b16.in_valid = 1'b1;
    b16.in_op    = op_e'(op);
    b16.in_data  = d;
    b16.in_shamt = s;
    @(negedge clk);
    n_checks++;
    if (b16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, b16.in_ready);
    end
    @(posedge clk);
    #1 b16.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b16.out_valid && lat < 10);
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles required 3", name, lat);
    end
    n_checks++;
    if (b16.out_data !== expv || b16.out_zero !== (expv == 16'd0)) begin
      n_fail++;
      $display("FAIL %s_value: data=%h zero=%b required data=%h zero=%b",
               name, b16.out_data, b16.out_zero, expv, (expv == 16'd0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single32(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] expv);
    int lat;
    b32.in_valid = 1'b1;
    b32.in_op    = op_e'(op);
    b32.in_data  = d;
    b32.in_shamt = s;
    @(negedge clk);
    n_checks++;
    if (b32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, b32.in_ready);
    end
    @(posedge clk);
    #1 b32.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b32.out_valid && lat < 10);
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles required 4", name, lat);
    end
    n_checks++;
    if (b32.out_data !== expv || b32.out_zero !== (expv == 32'd0)) begin
      n_fail++;
      $display("FAIL %s_value: data=%h zero=%b required data=%h zero=%b",
               name, b32.out_data, b32.out_zero, expv, (expv == 32'd0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results missing required 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (b16.out_valid !== 1'b0 || b16.out_data !== 16'h0 || b16.out_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h zero=%b required 0 0000 1",
               b16.out_valid, b16.out_data, b16.out_zero);
    end
    n_checks++;
    if (b32.out_valid !== 1'b0 || b32.out_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs32: valid=%b zero=%b required 0 1", b32.out_valid, b32.out_zero);
    end
    #10 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", b16.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    single16("sll15", 2'd0, 16'h0001, 4'd15, 16'h8000);
    single16("srl15", 2'd1, 16'h8000, 4'd15, 16'h0001);
    single16("sra15", 2'd2, 16'h8000, 4'd15, 16'hFFFF);
    single16("ror4",  2'd3, 16'h1234, 4'd4,  16'h4123);
    single16("sra_pos", 2'd2, 16'h7FFF, 4'd15, 16'h0000);
    single16("ror0",  2'd3, 16'hBEEF, 4'd0,  16'hBEEF);
    single16("sra0",  2'd2, 16'h8421, 4'd0,  16'h8421);
  endtask

  task automatic test_sweep();
    for (int op = 0; op < 4; op++) begin
      for (int s = 0; s < 16; s++) begin
        drive_op(2'(op), 16'($urandom), 4'(s));
      end
    end
    b16.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_drained("sweep");
  endtask

  task automatic test_backpressure();
    int x0;
    x0 = n_xfer;
    b16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_op(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
    b16.in_op    = OP_ROR;
    b16.in_data  = 16'($urandom);
    b16.in_shamt = 4'($urandom_range(1, 15));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (b16.in_ready !== 1'b0 || b16.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_full: in_ready=%b out_valid=%b required 0 1", b16.in_ready, b16.out_valid);
      end
      @(posedge clk);
      #1;
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_refill: in_ready=%b required 1", b16.in_ready);
    end
    @(posedge clk);
    #1 b16.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (n_xfer - x0 != 4) begin
      n_fail++;
      $display("FAIL bp_count: %0d results required 4", n_xfer - x0);
    end
    check_drained("bp");
  endtask

  task automatic test_flush();
    b16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_op(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
    b16.in_data = 16'h5555;
    flush16     = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b16.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: in_ready=%b required 0", b16.in_ready);
    end
    @(posedge clk);
    #1;
    flush16       = 1'b0;
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (b16.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_empty: out_valid=%b required 0 (cycle %0d)", b16.out_valid, i);
      end
    end
    @(posedge clk);
    #1;
    single16("post_flush", 2'd0, 16'h00F0, 4'd4, 16'h0F00);
  endtask

  task automatic test_reset_midop();
    b16.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_op(2'd3, 16'($urandom_range(1, 65535)), 4'd0);
    b16.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b16.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: out_valid=%b required 1", b16.out_valid);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (b16.out_valid !== 1'b0 || b16.out_data !== 16'h0 || b16.out_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h zero=%b required 0 0000 1",
               b16.out_valid, b16.out_data, b16.out_zero);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    b16.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (b16.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_after_reset: out_valid=%b required 0 (cycle %0d)", b16.out_valid, i);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      b16.in_valid  = 1'($urandom_range(0, 1));
      b16.in_op     = op_e'($urandom_range(0, 3));
      b16.in_data   = 16'($urandom);
      b16.in_shamt  = 4'($urandom_range(0, 15));
      b16.out_ready = ($urandom_range(0, 3) != 0);
      flush16       = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    flush16       = 1'b0;
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_drained("random");
  endtask

  task automatic test_w32();
    logic [31:0] d;
    logic [31:0] e;
    logic [4:0]  s;
    logic [1:0]  op;
    single32("w32_ror31", 2'd3, 32'h80000001, 5'd31, 32'h00000003);
    single32("w32_sra31", 2'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) begin
      d  = $urandom;
      s  = 5'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      e  = ref_shift(32, op, d, int'(s));
      single32("w32_rand", op, d, s, e);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks      = 0;
    n_fail        = 0;
    n_xfer        = 0;
    prev_stall    = 1'b0;
    prev_data     = '0;
    flush16       = 1'b0;
    flush32       = 1'b0;
    b16.in_valid  = 1'b0;
    b16.in_op     = OP_SLL;
    b16.in_data   = '0;
    b16.in_shamt  = '0;
    b16.out_ready = 1'b1;
    b32.in_valid  = 1'b0;
    b32.in_op     = OP_SLL;
    b32.in_data   = '0;
    b32.in_shamt  = '0;
    b32.out_ready = 1'b1;

    test_reset();
    test_directed();
    test_sweep();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    test_w32();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
